i2c_codec_responder: RTL and testbench
======================================

I2C_CODEC_RESPONDER -- requirements
Module: i2c_codec_responder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter DEV_ADDR, default 7'b0011010, is the 7-bit device address to which the block responds.
REQ-003 Port i_clk, input, width 1: system clock, at least 8x the SCL rate.
REQ-004 Port i_rst, input, width 1: synchronous active-high reset.
REQ-005 Port i_sclk, input, width 1: I2C SCL, asynchronous to i_clk.
REQ-006 Port i_sdat, input, width 1: I2C SDA as seen on the bus, asynchronous to i_clk.
REQ-007 Port o_sdat_oen, output, width 1: 1 = pull SDA low (ACK); 0 = release SDA.
REQ-008 Port o_wr_valid, output, width 1: one-cycle pulse when a register word is accepted.
REQ-009 Port o_wr_addr, output, width 7: register address of the accepted word.
REQ-010 Port o_wr_data, output, width 9: register data of the accepted word.
REQ-011 Port i_rd_addr, input, width 4: register file read index.
REQ-012 Port o_rd_data, output, width 9: combinational read of the register at i_rd_addr; reads 0 for indices 10-15.
REQ-013 Port o_busy, output, width 1: high from a START until the next STOP.
REQ-014 Port o_codec_reset, output, width 1: one-cycle pulse on a write to register 15.

Function
REQ-015 i_sclk and i_sdat SHALL each pass through a 2-FF synchronizer; edges are detected on the synchronized copies; all events below refer to the synchronized signals.
REQ-016 START is SDA falling while SCL is high; STOP is SDA rising while SCL is high; both are recognized in every state.
REQ-017 States SHALL be IDLE, ADDR, ACK_A, HI, ACK_H, LO, ACK_L, and NACK.
REQ-018 START moves the FSM to ADDR and clears the bit counter, including a repeated START mid-transfer; STOP moves the FSM to IDLE from any state.
REQ-019 In ADDR, HI and LO, data bits SHALL be shifted in MSB-first on each SCL rising edge; the byte is complete after 8 bits.
REQ-020 ADDR byte: if bits[7:1] equal DEV_ADDR and bit0 is 0, go to ACK_A; otherwise go to NACK.
REQ-021 ACK phase: o_sdat_oen SHALL be asserted on the first SCL falling edge after the 8th bit and deasserted on the following SCL falling edge.
REQ-022 After the ACK, the FSM proceeds ACK_A to HI, ACK_H to LO, and ACK_L to NACK.
REQ-023 HI byte: bits[7:1] form the register address and bit0 forms data bit 8; the LO byte forms data bits[7:0].
REQ-024 On completion of the LO byte, on the cycle the ACK drive begins, the block SHALL pulse o_wr_valid for 1 cycle with o_wr_addr and o_wr_data valid in that cycle; outputs hold until the next word.
REQ-025 Register file: addresses 0-9 are stored (10 x 9 bits); a write to address 15 clears all stored registers to 0 and pulses o_codec_reset in the same cycle as o_wr_valid; other addresses pulse o_wr_valid only.
REQ-026 In NACK, the block SHALL never drive SDA; it counts and ignores bytes until START or STOP; bytes beyond the third in a transaction are not ACKed and are not written.
REQ-027 A STOP or repeated START before the LO byte completes SHALL discard the partial word with no write and no pulse.
REQ-028 o_sdat_oen SHALL be 0 in every state except the ACK window; a STOP or START during the ACK window releases it on the next cycle.
REQ-029 o_busy SHALL be set on START and cleared on STOP.

Reset
REQ-030 When i_rst is high on a rising edge of i_clk: FSM goes to IDLE; bit counter and shift register go to 0; o_sdat_oen, o_wr_valid, o_codec_reset and o_busy go to 0; o_wr_addr and o_wr_data go to 0; all registers go to 0; synchronizers go to 1.
REQ-031 Reset asserted mid-transaction SHALL release SDA within 1 cycle; the block ignores the bus until the next START.

Verification
REQ-032 START, 0x34, 0x12, 0x01, STOP -> three ACKs; o_wr_valid pulse with addr 9, data 0x001; o_rd_data at index 9 = 0x001.
REQ-033 START, 0x36, 0x00, 0x00, STOP -> SDA never driven; no write; o_busy goes 1 then 0.
REQ-034 START, 0x35 (read bit set) -> NACK; SDA never driven thereafter.
REQ-035 Write reg 4 = 0x015, then START, 0x34, 0x1E, 0x00, STOP -> o_codec_reset pulse; index 4 reads 0.
REQ-036 START, 0x34, 0x0E, STOP after 4 bits of the LO byte -> no write; then a full transaction succeeds.
REQ-037 i_rst pulsed during the ACK of the HI byte -> o_sdat_oen = 0 on the next cycle; no write; the next transaction ACKs normally.

Source files
------------

// File: rtl/i2c_codec_responder.sv
`default_nettype none
// ============================================================================
// Module      : i2c_codec_responder
// Description : Write-only I2C target for an audio codec control port. It
//               accepts 3-byte words (device address, HI, LO), ACKs them,
//               and keeps a 10 x 9-bit register file. A write to register
//               15 clears the file and pulses a codec reset.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_codec_responder #(
    parameter logic [6:0] DEV_ADDR = 7'b0011010
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sclk,
    input  logic       i_sdat,
    output logic       o_sdat_oen,
    output logic       o_wr_valid,
    output logic [6:0] o_wr_addr,
    output logic [8:0] o_wr_data,
    input  logic [3:0] i_rd_addr,
    output logic [8:0] o_rd_data,
    output logic       o_busy,
    output logic       o_codec_reset
);

    localparam logic [6:0] c_NUM_REGS   = 7'd10;
    localparam logic [6:0] c_RESET_ADDR = 7'd15;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ACK_A, S_HI, S_ACK_H, S_LO, S_ACK_L, S_NACK
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  scl_sync_q, sda_sync_q;
    logic        scl_prev_q, sda_prev_q;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        oen_q, oen_d;
    logic        busy_q, busy_d;
    logic        wr_valid_q, wr_valid_d;
    logic [6:0]  wr_addr_q, wr_addr_d;
    logic [8:0]  wr_data_q, wr_data_d;
    logic        codec_rst_q, codec_rst_d;
    logic [6:0]  hi_addr_q, hi_addr_d;
    logic        hi_bit8_q, hi_bit8_d;
    logic [8:0]  regs_q [0:9];

    logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop, w_byte_done;

    assign w_scl       = scl_sync_q[1];
    assign w_sda       = sda_sync_q[1];
    assign w_scl_rise  = w_scl & ~scl_prev_q;
    assign w_scl_fall  = ~w_scl & scl_prev_q;
    // START/STOP need SCL stable high across the SDA transition
    assign w_start     = w_scl & scl_prev_q & sda_prev_q & ~w_sda;
    assign w_stop      = w_scl & scl_prev_q & ~sda_prev_q & w_sda;
    assign w_byte_done = (bitcnt_q == 4'd8);

    // Bring the bus lines into the clock domain and keep one-cycle history
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], i_sclk};
            sda_sync_q <= {sda_sync_q[0], i_sdat};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    // Protocol FSM: next state, bit capture, ACK drive and write strobe
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        oen_d       = oen_q;
        busy_d      = busy_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        codec_rst_d = 1'b0;
        hi_addr_d   = hi_addr_q;
        hi_bit8_d   = hi_bit8_q;

        if (w_start) begin
            state_d  = S_ADDR;
            bitcnt_d = 4'd0;
            oen_d    = 1'b0;
            busy_d   = 1'b1;
        end else if (w_stop) begin
            state_d  = S_IDLE;
            bitcnt_d = 4'd0;
            oen_d    = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_HI, S_LO: begin
                    if (w_scl_rise && !w_byte_done) begin
                        shift_d  = {shift_q[6:0], w_sda};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (w_scl_fall && w_byte_done) begin
                        // First falling edge after the 8th bit opens the ACK slot
                        bitcnt_d = 4'd0;
                        oen_d    = 1'b1;
                        if (state_q == S_ADDR) begin
                            if (shift_q[7:1] == DEV_ADDR && !shift_q[0]) begin
                                state_d = S_ACK_A;
                            end else begin
                                state_d = S_NACK;
                                oen_d   = 1'b0;
                            end
                        end else if (state_q == S_HI) begin
                            hi_addr_d = shift_q[7:1];
                            hi_bit8_d = shift_q[0];
                            state_d   = S_ACK_H;
                        end else begin
                            wr_valid_d  = 1'b1;
                            wr_addr_d   = hi_addr_q;
                            wr_data_d   = {hi_bit8_q, shift_q};
                            codec_rst_d = (hi_addr_q == c_RESET_ADDR);
                            state_d     = S_ACK_L;
                        end
                    end
                end
                S_ACK_A, S_ACK_H, S_ACK_L: begin
                    if (w_scl_fall) begin
                        oen_d    = 1'b0;
                        bitcnt_d = 4'd0;
                        case (state_q)
                            S_ACK_A: state_d = S_HI;
                            S_ACK_H: state_d = S_LO;
                            default: state_d = S_NACK;
                        endcase
                    end
                end
                S_NACK: begin
                    // Track byte framing (8 data + 1 ack clock) without responding
                    if (w_scl_rise) begin
                        shift_d  = {shift_q[6:0], w_sda};
                        bitcnt_d = (bitcnt_q == 4'd8) ? 4'd0 : bitcnt_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            bitcnt_q    <= 4'd0;
            shift_q     <= 8'd0;
            oen_q       <= 1'b0;
            busy_q      <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= 7'd0;
            wr_data_q   <= 9'd0;
            codec_rst_q <= 1'b0;
            hi_addr_q   <= 7'd0;
            hi_bit8_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            oen_q       <= oen_d;
            busy_q      <= busy_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            codec_rst_q <= codec_rst_d;
            hi_addr_q   <= hi_addr_d;
            hi_bit8_q   <= hi_bit8_d;
        end
    end

    // Register file: updated on the same edge that raises o_wr_valid
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 10; i++) regs_q[i] <= 9'd0;
        end else if (wr_valid_d) begin
            if (wr_addr_d == c_RESET_ADDR) begin
                for (int i = 0; i < 10; i++) regs_q[i] <= 9'd0;
            end else if (wr_addr_d < c_NUM_REGS) begin
                regs_q[wr_addr_d[3:0]] <= wr_data_d;
            end
        end
    end

    // Combinational read port; unimplemented indices read as zero
    always_comb begin
        o_rd_data = 9'd0;
        if (i_rd_addr < c_NUM_REGS[3:0]) o_rd_data = regs_q[i_rd_addr];
    end

    assign o_sdat_oen    = oen_q;
    assign o_wr_valid    = wr_valid_q;
    assign o_wr_addr     = wr_addr_q;
    assign o_wr_data     = wr_data_q;
    assign o_busy        = busy_q;
    assign o_codec_reset = codec_rst_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_codec_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_codec_responder
// Description : Bus-level bench: an I2C master model drives the responder,
//               a directed vector table and random transactions are checked
//               against a register-file reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_codec_responder;

    localparam logic [6:0] DEV = 7'b0011010;
    localparam int         Q   = 6;   // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [3:0] rd_addr = 4'd0;
    logic       sdat_oen, wr_valid, busy, codec_reset;
    logic [6:0] wr_addr;
    logic [8:0] wr_data, rd_data;
    logic       sda_bus;

    assign sda_bus = m_sda & ~sdat_oen;

    i2c_codec_responder #(.DEV_ADDR(DEV)) dut (
        .i_clk(clk), .i_rst(rst), .i_sclk(m_scl), .i_sdat(sda_bus),
        .o_sdat_oen(sdat_oen), .o_wr_valid(wr_valid), .o_wr_addr(wr_addr),
        .o_wr_data(wr_data), .i_rd_addr(rd_addr), .o_rd_data(rd_data),
        .o_busy(busy), .o_codec_reset(codec_reset)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    logic [8:0] mdl [16];

    // Event counters, sampled on the falling clock edge
    int wr_cyc = 0, crst_cyc = 0, crst_with_wr = 0, oen_cyc = 0;
    always @(negedge clk) begin
        if (wr_valid) wr_cyc <= wr_cyc + 1;
        if (codec_reset) crst_cyc <= crst_cyc + 1;
        if (codec_reset && wr_valid) crst_with_wr <= crst_with_wr + 1;
        if (sdat_oen) oen_cyc <= oen_cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic waitq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; waitq();
        m_scl = 1'b1; waitq();
        m_sda = 1'b0; waitq();
        m_scl = 1'b0; waitq();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; waitq();
        m_scl = 1'b1; waitq();
        m_sda = 1'b1; waitq(); waitq();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            m_sda = b[7-i]; waitq();
            m_scl = 1'b1; waitq(); waitq();
            m_scl = 1'b0; waitq();
        end
    endtask

    task automatic ack_bit(output logic acked);
        m_sda = 1'b1; waitq();
        m_scl = 1'b1; waitq();
        acked = (sda_bus == 1'b0);
        waitq();
        m_scl = 1'b0; waitq();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        send_bits(b, 8);
        ack_bit(acked);
    endtask

    // Reference model: what a well-behaved codec target does with a byte list
    function automatic void predict(input logic [39:0] bytes, input int nfull,
                                    output logic [4:0] acks, output logic wr,
                                    output logic [6:0] addr, output logic [8:0] data);
        logic match;
        match = (bytes[39:32] == {DEV, 1'b0});
        acks  = '0;
        for (int i = 0; i < nfull; i++) acks[i] = match && (i < 3);
        wr    = match && (nfull >= 3);
        addr  = bytes[31:25];
        data  = {bytes[24], bytes[23:16]};
    endfunction

    function automatic void model_write(input logic [6:0] addr, input logic [8:0] data);
        if (addr == 7'd15) begin
            for (int i = 0; i < 10; i++) mdl[i] = 9'd0;
        end else if (addr < 7'd10) begin
            mdl[addr[3:0]] = data;
        end
    endfunction

    // One transaction from START to STOP, compared against the given expectation
    task automatic txn_check(input logic [39:0] bytes, input int nfull, input int npart,
                             input logic [4:0] e_acks, input logic e_wr,
                             input logic [6:0] e_addr, input logic [8:0] e_data,
                             input logic e_crst);
        int w0, c0, cw0, o0;
        logic [4:0] acks;
        logic a;
        w0 = wr_cyc; c0 = crst_cyc; cw0 = crst_with_wr; o0 = oen_cyc;
        acks = '0;
        i2c_start();
        check("busy_after_start", {31'd0, busy}, 32'd1);
        for (int i = 0; i < nfull; i++) begin
            send_byte(bytes[39-8*i -: 8], a);
            acks[i] = a;
        end
        if (npart > 0 && nfull < 5) send_bits(bytes[39-8*nfull -: 8], npart);
        i2c_stop();
        check("busy_after_stop", {31'd0, busy}, 32'd0);
        check("ack_pattern", {27'd0, acks}, {27'd0, e_acks});
        check("wr_pulse_cycles", wr_cyc - w0, e_wr ? 32'd1 : 32'd0);
        check("codec_reset_cycles", crst_cyc - c0, e_crst ? 32'd1 : 32'd0);
        check("codec_reset_with_wr", crst_with_wr - cw0, e_crst ? 32'd1 : 32'd0);
        if (e_acks == 5'd0) check("sda_never_driven", oen_cyc - o0, 32'd0);
        if (e_wr) begin
            check("wr_addr", {25'd0, wr_addr}, {25'd0, e_addr});
            check("wr_data", {23'd0, wr_data}, {23'd0, e_data});
            model_write(e_addr, e_data);
        end
    endtask

    task automatic check_all_regs();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rd_addr = 4'(i);
            #1;
            check($sformatf("rd_data[%0d]", i), {23'd0, rd_data}, {23'd0, mdl[i]});
        end
    endtask

    typedef struct {
        logic [39:0] bytes;
        int          nfull;
        int          npart;
        logic [4:0]  acks;
        logic        wr;
        logic [6:0]  addr;
        logic [8:0]  data;
        logic        crst;
        logic [3:0]  ri;
        logic [8:0]  rd;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       a;
        logic [4:0] e_acks;
        logic       e_wr;
        logic [6:0] e_addr;
        logic [8:0] e_data;
        logic [39:0] bytes;
        int nfull, npart, w0;
        logic [6:0] raddr;
        logic [8:0] rdata;

        tbl[0] = '{40'h3412010000, 3, 0, 5'b00111, 1'b1, 7'd9,  9'h001, 1'b0, 4'd9, 9'h001};
        tbl[1] = '{40'h3600000000, 3, 0, 5'b00000, 1'b0, 7'd0,  9'h000, 1'b0, 4'd9, 9'h001};
        tbl[2] = '{40'h3500000000, 1, 0, 5'b00000, 1'b0, 7'd0,  9'h000, 1'b0, 4'd9, 9'h001};
        tbl[3] = '{40'h3408150000, 3, 0, 5'b00111, 1'b1, 7'd4,  9'h015, 1'b0, 4'd4, 9'h015};
        tbl[4] = '{40'h341E000000, 3, 0, 5'b00111, 1'b1, 7'd15, 9'h000, 1'b1, 4'd4, 9'h000};
        tbl[5] = '{40'h341201AA00, 4, 0, 5'b00111, 1'b1, 7'd9,  9'h001, 1'b0, 4'd9, 9'h001};
        tbl[6] = '{40'h340EFF0000, 2, 4, 5'b00011, 1'b0, 7'd0,  9'h000, 1'b0, 4'd9, 9'h001};
        tbl[7] = '{40'h3412050000, 3, 0, 5'b00111, 1'b1, 7'd9,  9'h005, 1'b0, 4'd9, 9'h005};

        for (int i = 0; i < 16; i++) mdl[i] = 9'd0;

        // Reset state
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_oen", {31'd0, sdat_oen}, 32'd0);
        check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_codec_reset", {31'd0, codec_reset}, 32'd0);
        check("rst_wr_addr", {25'd0, wr_addr}, 32'd0);
        check("rst_wr_data", {23'd0, wr_data}, 32'd0);
        check_all_regs();

        // Directed vector table
        for (int v = 0; v < 8; v++) begin
            txn_check(tbl[v].bytes, tbl[v].nfull, tbl[v].npart, tbl[v].acks,
                      tbl[v].wr, tbl[v].addr, tbl[v].data, tbl[v].crst);
            @(negedge clk);
            rd_addr = tbl[v].ri;
            #1;
            check($sformatf("tbl%0d_rd_data", v), {23'd0, rd_data}, {23'd0, tbl[v].rd});
        end
        check_all_regs();

        // Reset pulsed while the HI byte is being ACKed
        w0 = wr_cyc;
        i2c_start();
        send_byte(8'h34, a);
        check("rstmid_addr_ack", {31'd0, a}, 32'd1);
        send_bits(8'h12, 8);
        m_sda = 1'b1; waitq();
        m_scl = 1'b1; waitq();
        check("rstmid_oen_before", {31'd0, sdat_oen}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_oen_released", {31'd0, sdat_oen}, 32'd0);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 16; i++) mdl[i] = 9'd0;
        waitq();
        m_scl = 1'b0; waitq();
        send_byte(8'h01, a);
        check("rstmid_lo_ignored", {31'd0, a}, 32'd0);
        i2c_stop();
        check("rstmid_no_write", wr_cyc - w0, 32'd0);
        txn_check(40'h3410230000, 3, 0, 5'b00111, 1'b1, 7'd8, 9'h023, 1'b0);
        check_all_regs();

        // Randomized transactions against the reference model
        for (int t = 0; t < 20; t++) begin
            raddr = ($urandom_range(0, 7) == 0) ? 7'd15 : 7'($urandom_range(0, 12));
            rdata = 9'($urandom);
            bytes = {($urandom_range(0, 3) != 0) ? 8'h34 : 8'($urandom),
                     raddr, rdata[8], rdata[7:0], 8'($urandom), 8'($urandom)};
            nfull = $urandom_range(1, 5);
            npart = (nfull < 5 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            predict(bytes, nfull, e_acks, e_wr, e_addr, e_data);
            txn_check(bytes, nfull, npart, e_acks, e_wr, e_addr, e_data,
                      e_wr && (e_addr == 7'd15));
            check_all_regs();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
